// File: rtl/seq_signed_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_signed_divider_if
// Brief    : Start/busy/done handshake and operand/result bundle for the
//            sequential signed divider.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_signed_divider_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);
  logic                         start;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic signed [DIVISOR_W-1:0]  divisor;
  logic signed [DIVIDEND_W-1:0] quotient;
  logic signed [DIVISOR_W-1:0]  remainder;
  logic                         busy;
  logic                         done;
  logic                         div_by_zero;
  logic                         overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface
`default_nettype wire

// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_signed_divider
// Brief    : Multi-cycle signed divider; restoring shift-subtract on operand
//            magnitudes, one quotient bit per clock, then a sign fix-up step.
// Revision : 1.0 - initial release
// ============================================================================
module seq_signed_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  seq_signed_divider_if.slave bus
);
  localparam int              c_CW   = $clog2(DIVIDEND_W + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DIVIDEND_W - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;
  localparam logic [1:0] c_ZERO = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [c_CW-1:0]       r_count;
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVISOR_W:0]    r_dvs;
  logic [DIVISOR_W-1:0]  r_rem;
  logic                  r_sign_q;
  logic                  r_sign_r;
  logic [DIVIDEND_W-1:0] r_quo;
  logic [DIVISOR_W-1:0]  r_rmd;
  logic                  r_done;
  logic                  r_dbz;
  logic                  r_ovf;

  logic                  w_busy;
  logic                  w_load;
  logic                  w_step;
  logic                  w_fix;
  logic                  w_zero;

  logic [DIVIDEND_W-1:0] w_abs_dvd;
  logic [DIVISOR_W:0]    w_dvs_ext;
  logic [DIVISOR_W:0]    w_abs_dvs;
  logic [DIVISOR_W:0]    w_part;
  logic                  w_ge;
  logic [DIVISOR_W-1:0]  w_diff;
  logic [DIVISOR_W-1:0]  w_rem_next;

  // Divisor is widened by one bit so that |-2^(DIVISOR_W-1)| is representable.
  assign w_abs_dvd = bus.dividend[DIVIDEND_W-1] ? -bus.dividend : bus.dividend;
  assign w_dvs_ext = {bus.divisor[DIVISOR_W-1], bus.divisor};
  assign w_abs_dvs = w_dvs_ext[DIVISOR_W] ? -w_dvs_ext : w_dvs_ext;

  // Partial remainder never exceeds 2*|divisor|-1, and the kept remainder is
  // always below |divisor|, so the low DIVISOR_W bits of the difference suffice.
  assign w_part     = {r_rem, r_dvd[DIVIDEND_W-1]};
  assign w_ge       = (w_part >= r_dvs);
  assign w_diff     = w_part[DIVISOR_W-1:0] - r_dvs[DIVISOR_W-1:0];
  assign w_rem_next = w_ge ? w_diff : w_part[DIVISOR_W-1:0];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (bus.start) begin
          w_next = (bus.divisor == '0) ? c_ZERO : c_CALC;
        end
      end
      c_CALC: begin
        if (r_count == c_LAST) begin
          w_next = c_FIX;
        end
      end
      c_FIX:   w_next = c_IDLE;
      c_ZERO:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != c_IDLE);
    w_load = (r_state == c_IDLE) && bus.start;
    w_step = (r_state == c_CALC);
    w_fix  = (r_state == c_FIX);
    w_zero = (r_state == c_ZERO);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_quo    <= '0;
      r_rmd    <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_count  <= '0;
        r_dvd    <= w_abs_dvd;
        r_dvs    <= w_abs_dvs;
        r_rem    <= '0;
        r_sign_q <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
        r_sign_r <= bus.dividend[DIVIDEND_W-1];
        r_dbz    <= 1'b0;
        r_ovf    <= 1'b0;
      end else if (w_step) begin
        // Dividend bits shift out the top while quotient bits fill the bottom.
        r_rem   <= w_rem_next;
        r_dvd   <= {r_dvd[DIVIDEND_W-2:0], w_ge};
        r_count <= r_count + c_CW'(1);
      end else if (w_fix) begin
        r_quo  <= r_sign_q ? -r_dvd : r_dvd;
        r_rmd  <= r_sign_r ? -r_rem : r_rem;
        r_ovf  <= !r_sign_q && r_dvd[DIVIDEND_W-1];
        r_done <= 1'b1;
      end else if (w_zero) begin
        r_quo  <= '0;
        r_rmd  <= '0;
        r_dbz  <= 1'b1;
        r_done <= 1'b1;
      end
    end
  end

  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rmd;
  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_signed_divider
// Brief    : Directed and exhaustive self-checking bench for seq_signed_divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_signed_divider;
  logic clock = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  seq_signed_divider_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) bus ();

  seq_signed_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // lat counts clock edges after the accepting edge until done is seen.
  task automatic run_div(input logic signed [7:0] a, input logic signed [3:0] b,
                         input bit now, output int lat);
    if (!now) @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clock);
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus.start    = 1'b1;
    bus.dividend = 8'sd100;
    bus.divisor  = 4'sd7;
    repeat (3) @(negedge clock);
    total++;
    if (bus.quotient !== 8'd0 || bus.remainder !== 4'd0) begin
      bad++;
      $display("FAIL reset_data: got q=%0d r=%0d want q=0 r=0", bus.quotient, bus.remainder);
    end
    total++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.overflow} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: got busy/done/dbz/ovf=%b want 0000",
               {bus.busy, bus.done, bus.div_by_zero, bus.overflow});
    end
    reset_n   = 1'b1;
    bus.start = 1'b0;
    @(negedge clock);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int ta [7] = '{100, -100, 127, -128, -128, -7, 7};
    int tb_[7] = '{7, 7, -8, -1, -8, 2, -2};
    int tq [7] = '{14, -14, -15, -128, 16, -3, -3};
    int tr [7] = '{2, -2, 7, 0, 0, -1, 1};
    int tov[7] = '{0, 0, 0, 1, 0, 0, 0};
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_div(8'(ta[i]), 4'(tb_[i]), 1'b0, lat);
      total++;
      if (lat !== 9) begin
        bad++;
        $display("FAIL basic_latency[%0d]: got %0d want 9", i, lat);
      end
      total++;
      if (bus.quotient !== 8'(tq[i]) || bus.remainder !== 4'(tr[i])) begin
        bad++;
        $display("FAIL basic_result[%0d] %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d",
                 i, ta[i], tb_[i], bus.quotient, bus.remainder, tq[i], tr[i]);
      end
      total++;
      if (bus.overflow !== 1'(tov[i]) || bus.div_by_zero !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL basic_flags[%0d]: got ovf=%b dbz=%b busy=%b want ovf=%0d dbz=0 busy=0",
                 i, bus.overflow, bus.div_by_zero, bus.busy, tov[i]);
      end
      @(negedge clock);
      total++;
      if (bus.done !== 1'b0 || bus.quotient !== 8'(tq[i]) || bus.overflow !== 1'(tov[i])) begin
        bad++;
        $display("FAIL basic_hold[%0d]: got done=%b q=%0d ovf=%b want done=0 q=%0d ovf=%0d",
                 i, bus.done, bus.quotient, bus.overflow, tq[i], tov[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    run_div(-8'sd128, -4'sd1, 1'b0, lat);
    run_div(8'sd5, 4'sd0, 1'b0, lat);
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL zero_latency: got %0d want 1", lat);
    end
    total++;
    if (bus.quotient !== 8'd0 || bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b1 ||
        bus.overflow !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_result: got q=%0d r=%0d dbz=%b ovf=%b busy=%b want 0 0 1 0 0",
               bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, bus.busy);
    end
    repeat (2) @(negedge clock);
    total++;
    if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL zero_hold: got done=%b dbz=%b want done=0 dbz=1", bus.done, bus.div_by_zero);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int extra;
    @(negedge clock);
    bus.start = 1'b1; bus.dividend = 8'sd50; bus.divisor = 4'sd3;
    @(negedge clock);
    bus.start = 1'b0; bus.dividend = 8'sd0; bus.divisor = 4'sd0;
    repeat (3) @(negedge clock);
    bus.start = 1'b1; bus.dividend = 8'sd9; bus.divisor = 4'sd9;
    @(negedge clock);
    bus.start = 1'b0;
    lat = 4;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    total++;
    if (lat !== 9 || bus.quotient !== 8'sd16 || bus.remainder !== 4'sd2) begin
      bad++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d want lat=9 q=16 r=2",
               lat, bus.quotient, bus.remainder);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL ignore_no_retrigger: got %0d busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    @(negedge clock);
    bus.start = 1'b1; bus.dividend = 8'sd100; bus.divisor = 4'sd7;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    total++;
    if (bus.quotient !== 8'd0 || bus.remainder !== 4'd0 ||
        {bus.busy, bus.done, bus.div_by_zero, bus.overflow} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset: got q=%0d r=%0d busy/done/dbz/ovf=%b want all 0",
               bus.quotient, bus.remainder, {bus.busy, bus.done, bus.div_by_zero, bus.overflow});
    end
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL mid_reset_abort: got %0d done pulses want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_div(8'sd100, 4'sd7, 1'b0, lat);
    total++;
    if (bus.quotient !== 8'sd14 || bus.remainder !== 4'sd2) begin
      bad++;
      $display("FAIL b2b_first: got q=%0d r=%0d want q=14 r=2", bus.quotient, bus.remainder);
    end
    run_div(-8'sd50, 4'sd7, 1'b1, lat);
    total++;
    if (lat !== 9 || bus.quotient !== -8'sd7 || bus.remainder !== -4'sd1) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d want lat=9 q=-7 r=-1",
               lat, bus.quotient, bus.remainder);
    end
    run_div(8'sd3, 4'sd0, 1'b1, lat);
    run_div(-8'sd8, 4'sd3, 1'b1, lat);
    total++;
    if (lat !== 9 || bus.quotient !== -8'sd2 || bus.remainder !== -4'sd2 ||
        bus.div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL b2b_flag_clear: got lat=%0d q=%0d r=%0d dbz=%b want lat=9 q=-2 r=-2 dbz=0",
               lat, bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_sweep();
    int lat, eq, er, el;
    logic ez, eo;
    for (int a = -128; a < 128; a++) begin
      for (int b = -8; b < 8; b++) begin
        run_div(8'(a), 4'(b), 1'b0, lat);
        ez = 1'b0; eo = 1'b0; el = 9;
        if (b == 0) begin
          eq = 0; er = 0; ez = 1'b1; el = 1;
        end else if (a == -128 && b == -1) begin
          eq = -128; er = 0; eo = 1'b1;
        end else begin
          eq = a / b; er = a % b;
        end
        total++;
        if (lat !== el || bus.quotient !== 8'(eq) || bus.remainder !== 4'(er) ||
            bus.div_by_zero !== ez || bus.overflow !== eo) begin
          bad++;
          $display("FAIL sweep %0d/%0d: got lat=%0d q=%0d r=%0d dbz=%b ovf=%b want lat=%0d q=%0d r=%0d dbz=%b ovf=%b",
                   a, b, lat, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow,
                   el, eq, er, ez, eo);
        end
      end
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
